crc8_serial_checker: RTL
========================

# crc8_serial_checker

Receive-side CRC-8 checker for the serial CRC link. It absorbs a serial, LSB-first data stream, then compares the 8 trailing CRC bits against its own LFSR remainder. It reports a one-cycle DONE pulse with a held pass/fail verdict. It sits at the far end of the link, downstream of the serial CRC generator, and uses the identical polynomial, seed and bit order.

## Interface
Parameters:
- SEED, default 8'hD8, LFSR value loaded at reset and at every frame start.

Ports (reset RST, asynchronous, active-low; clock CLK):
- CLK  in  1  clock, all sampling on rising edge
- RST  in  1  asynchronous active-low reset
- ACTIVE  in  1  data phase qualifier: DATA is a payload bit this cycle
- CRC_VALID  in  1  CRC phase qualifier: DATA is a received CRC bit this cycle
- DATA  in  1  serial bit, payload LSB-first, then CRC LSB-first
- DONE  out  1  one-cycle pulse, verdict updated
- CRC_OK  out  1  last frame's CRC matched; held until next DONE
- CRC_ERR  out  1  last frame's CRC mismatched; held until next DONE
- BUSY  out  1  high in DATA or CHECK state

## Operation
- LFSR step, fb = LFSR[0]^DATA: [7]=fb, [6]=fb^[7], [5]=[6], [4]=[5], [3]=[4], [2]=fb^[3], [1]=[2], [0]=[1].
- Expected CRC bit is LFSR[0]. On each accepted CRC bit, LFSR shifts right by 1 and the MSB is filled with 0.
- FSM states and transitions:
  - IDLE, LFSR = SEED.
    - ACTIVE=1: step LFSR with DATA and go to DATA.
    - ACTIVE=0, CRC_VALID=1: zero-length frame. Compare DATA against SEED[0] and go to CHECK with bit count 1.
  - DATA:
    - ACTIVE=1: step.
    - ACTIVE=0, CRC_VALID=1: compare the first CRC bit and go to CHECK.
    - Both 0: stall and hold the LFSR.
  - CHECK: a 3-bit counter tracks CRC bits and a sticky mismatch flag ORs in (DATA != LFSR[0]).
    - Both 0: stall, holding LFSR, counter and flag.
    - On the 8th accepted CRC bit: DONE<=1, CRC_OK<=~mismatch_final, CRC_ERR<=mismatch_final, LFSR<=SEED, go to IDLE.
- Boundary rules:
  - ACTIVE and CRC_VALID both high: ACTIVE wins in every state.
  - ACTIVE high in CHECK: the frame is aborted with no DONE and CRC_OK/ERR unchanged. The LFSR reloads SEED and is stepped with this DATA in the same edge, and the FSM goes to DATA.
  - CRC_VALID after DONE (in IDLE) starts a new zero-length frame.
  - No payload length limit. The LFSR is unaffected by length.
  - RST mid-frame discards the frame with no DONE.

## Timing
- Reset values: DONE=0, CRC_OK=0, CRC_ERR=0, BUSY=0, LFSR=SEED, state IDLE, counter 0, mismatch 0.
- One bit accepted per qualified cycle. Stalls are allowed in any phase.
- DONE is high for exactly the one cycle after the edge that samples the 8th CRC bit. CRC_OK/CRC_ERR change on that same edge.
- CRC_OK and CRC_ERR are never both 1.
- Back-to-back frames: ACTIVE may be high in the DONE cycle, and that bit is accepted.
- BUSY is registered and goes low in the DONE cycle.

## Structure
- Shared package crc8_pkg holds:
  - CRC_W=8 and default SEED 8'hD8.
  - The state enum {IDLE, DATA, CHECK}.
  - A CRC_BITS=8 constant.
- Sub-module crc8_lfsr_step: purely combinational next-LFSR function (lfsr_in, bit_in → lfsr_out), reused by the generator side. The checker instantiates it once.

## Test plan
- Single payload bit 1: LFSR becomes 8'hA8. Then send CRC bits 0,0,0,1,0,1,0,1 → DONE pulse, CRC_OK=1, CRC_ERR=0.
- Single payload bit 0: LFSR 8'h6C. Send CRC bits of 8'h6C LSB-first with bit 3 flipped → DONE, CRC_ERR=1, CRC_OK=0.
- Zero-length frame: CRC_VALID only, bits of 8'hD8 (0,0,0,1,1,0,1,1) → CRC_OK=1. Repeat with random stall cycles inserted in both phases → same result and same DONE count.
- Abort: ACTIVE reasserted after 4 CRC bits → no DONE, verdict unchanged. The following frame checks correctly from SEED.
- Reset mid-frame: RST low during DATA, then a clean frame of payload 8'hA5 streamed against a reference model (generator output) → CRC_OK=1. Also cover two back-to-back frames with ACTIVE high in the DONE cycle → two DONE pulses.
- Randomized: 1000 frames, lengths 0–64, 10% corrupted CRC bit → CRC_ERR exactly on corrupted frames, one DONE per frame.

Source files
------------

// File: rtl/crc8_pkg.sv
// Shared CRC-8 constants and checker state encoding.
// Used by the serial checker and the reusable LFSR step.
package crc8_pkg;

    localparam int CRC_W    = 8;
    localparam int CRC_BITS = 8;

    localparam logic [CRC_W-1:0] DEFAULT_SEED = 8'hD8;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CHECK
    } state_t;

endpackage

// File: rtl/crc8_lfsr_step.sv
// One-bit CRC-8 LFSR advance (right-shifting, feedback from bit 0).
// Shared with the serial generator so both ends stay bit-exact.
module crc8_lfsr_step
    import crc8_pkg::*;
(
    input  logic [CRC_W-1:0] lfsr_in,
    input  logic             bit_in,
    output logic [CRC_W-1:0] lfsr_out
);

    logic fb;

    assign fb = lfsr_in[0] ^ bit_in;

    assign lfsr_out = {
        fb,
        fb ^ lfsr_in[7],
        lfsr_in[6],
        lfsr_in[5],
        lfsr_in[4],
        fb ^ lfsr_in[3],
        lfsr_in[2],
        lfsr_in[1]
    };

endmodule

// File: rtl/crc8_serial_checker.sv
// Receive-side serial CRC-8 checker: absorbs payload LSB-first, then
// compares 8 trailing CRC bits against the LFSR remainder.
module crc8_serial_checker
    import crc8_pkg::*;
#(
    parameter logic [CRC_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic CLK,
    input  logic RST,
    input  logic ACTIVE,
    input  logic CRC_VALID,
    input  logic DATA,
    output logic DONE,
    output logic CRC_OK,
    output logic CRC_ERR,
    output logic BUSY
);

    localparam logic [2:0] LAST_BIT = 3'(CRC_BITS - 1);

    state_t           state, state_n;
    logic [CRC_W-1:0] lfsr, lfsr_n;
    logic [2:0]       cnt, cnt_n;
    logic             mism, mism_n;
    logic             done_n, ok_n, err_n, busy_n;

    logic [CRC_W-1:0] step_src;
    logic [CRC_W-1:0] step_out;
    logic             bit_miss;
    logic             miss_final;

    // An abort from CHECK restarts the frame, so the step begins at SEED.
    assign step_src   = (state == CHECK) ? SEED : lfsr;
    assign bit_miss   = DATA ^ lfsr[0];
    assign miss_final = mism | bit_miss;

    crc8_lfsr_step u_step (
        .lfsr_in  (step_src),
        .bit_in   (DATA),
        .lfsr_out (step_out)
    );

    always_comb begin
        state_n = state;
        lfsr_n  = lfsr;
        cnt_n   = cnt;
        mism_n  = mism;
        done_n  = 1'b0;
        ok_n    = CRC_OK;
        err_n   = CRC_ERR;
        unique case (state)
            IDLE, crc8_pkg::DATA: begin
                if (ACTIVE) begin
                    lfsr_n  = step_out;
                    state_n = crc8_pkg::DATA;
                end else if (CRC_VALID) begin
                    lfsr_n  = lfsr >> 1;
                    cnt_n   = 3'd1;
                    mism_n  = bit_miss;
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (ACTIVE) begin
                    lfsr_n  = step_out;
                    cnt_n   = '0;
                    mism_n  = 1'b0;
                    state_n = crc8_pkg::DATA;
                end else if (CRC_VALID) begin
                    if (cnt == LAST_BIT) begin
                        done_n  = 1'b1;
                        ok_n    = ~miss_final;
                        err_n   = miss_final;
                        lfsr_n  = SEED;
                        cnt_n   = '0;
                        mism_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        lfsr_n = lfsr >> 1;
                        cnt_n  = cnt + 3'd1;
                        mism_n = miss_final;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                lfsr_n  = SEED;
                cnt_n   = '0;
                mism_n  = 1'b0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            lfsr    <= SEED;
            cnt     <= '0;
            mism    <= 1'b0;
            DONE    <= 1'b0;
            CRC_OK  <= 1'b0;
            CRC_ERR <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state   <= state_n;
            lfsr    <= lfsr_n;
            cnt     <= cnt_n;
            mism    <= mism_n;
            DONE    <= done_n;
            CRC_OK  <= ok_n;
            CRC_ERR <= err_n;
            BUSY    <= busy_n;
        end
    end

endmodule
